// File: rtl/fetch_stage.sv
// fetch_stage: RV32I fetch stage with in-order imem requests, instruction buffer and IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        keep,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_pype0,
  output logic [31:0] PCp4_pype0,
  output logic [31:0] Instraction_pype,
  output logic        nop_pype0
);
  localparam int AW = $clog2(IBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, disc_cnt_q, disc_cnt_d, fifo_cnt_q, fifo_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0] pc_mem_q [IBUF_DEPTH];
  logic [31:0] ins_mem_q [IBUF_DEPTH];
  logic [31:0] pc_q, pc_d, pcp4_q, pcp4_d, ins_q, ins_d;
  logic nop_q, nop_d;
  logic fire, rv, push, pop, hold;

  // a request is only issued if its response is guaranteed a buffer slot
  assign imem_req  = rst && !flush && ((int'(out_cnt_q) + int'(fifo_cnt_q)) < IBUF_DEPTH);
  assign imem_addr = fetch_pc_q;
  assign PC_pype0         = pc_q;
  assign PCp4_pype0       = pcp4_q;
  assign Instraction_pype = ins_q;
  assign nop_pype0        = nop_q;

  // handshake bookkeeping, buffer pointers and next IF/ID contents
  always_comb begin
    fire = imem_req && imem_gnt;
    rv   = imem_rvalid && (out_cnt_q != '0);
    push = rv && !flush && (disc_cnt_q == '0);
    pop  = !flush && !keep && (fifo_cnt_q != '0);
    hold = keep && !flush;
    fetch_pc_d = flush ? redirect_pc : (fire ? fetch_pc_q + 32'd4 : fetch_pc_q);
    resp_pc_d  = flush ? redirect_pc : (push ? resp_pc_q + 32'd4 : resp_pc_q);
    out_cnt_d  = out_cnt_q + CW'(fire) - CW'(rv);
    disc_cnt_d = flush ? out_cnt_q - CW'(rv) : disc_cnt_q - CW'(rv && (disc_cnt_q != '0));
    fifo_cnt_d = flush ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d   = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d   = flush ? '0 : rd_ptr_q + AW'(pop);
    pc_d   = pop ? pc_mem_q[rd_ptr_q] : pc_q;
    pcp4_d = pop ? pc_mem_q[rd_ptr_q] + 32'd4 : pcp4_q;
    ins_d  = hold ? ins_q : (pop ? ins_mem_q[rd_ptr_q] : NOP);
    nop_d  = hold ? nop_q : !pop;
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pc_q       <= '0;
      pcp4_q     <= '0;
      ins_q      <= NOP;
      nop_q      <= 1'b1;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pc_q       <= pc_d;
      pcp4_q     <= pcp4_d;
      ins_q      <= ins_d;
      nop_q      <= nop_d;
    end
  end

  // buffer storage; contents are meaningless outside the valid window so no reset
  always_ff @(posedge clk) begin
    if (rst && push) begin
      pc_mem_q[wr_ptr_q]  <= resp_pc_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end
endmodule
